// File: rtl/mux2_stream_arbiter.sv
// mux2_stream_arbiter: picks one of two valid/ready streams per cycle and
// registers the chosen word with the select that picked it.
// Contention is round-robin by default.
// Define MUX2_ARB_FIXED_PRIO_EN to make channel 0 always win contention.
module mux2_stream_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic             v0,
  output logic             r0,
  input  logic [WIDTH-1:0] d1,
  input  logic             v1,
  output logic             r1,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             s
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             s_q, s_d;
  logic             last_grant_q, last_grant_d;

  logic load;
  logic gnt_valid;
  logic gnt_ch;

  assign y_valid = (state_q == StFull);
  assign y       = y_q;
  assign s       = s_q;

  // Output slot can take a word when empty or when the held word leaves now.
  assign load = ~y_valid | y_ready;

  // Grant decision; depends only on valids and last_grant, never on y_ready.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_ch    = 1'b0;
    if (v0 && v1) begin
      gnt_valid = 1'b1;
`ifdef MUX2_ARB_FIXED_PRIO_EN
      gnt_ch    = 1'b0;
`else
      gnt_ch    = ~last_grant_q;
`endif
    end else if (v0) begin
      gnt_valid = 1'b1;
      gnt_ch    = 1'b0;
    end else if (v1) begin
      gnt_valid = 1'b1;
      gnt_ch    = 1'b1;
    end
  end

  // Readies; forced low in a reset cycle so no handshake completes.
  always_comb begin
    r0 = ~rst & load & gnt_valid & ~gnt_ch;
    r1 = ~rst & load & gnt_valid & gnt_ch;
  end

  // Next-state: load a granted word, drain when nothing is granted, else hold.
  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    s_d          = s_q;
    last_grant_d = last_grant_q;
    if (load) begin
      if (gnt_valid) begin
        state_d      = StFull;
        y_d          = gnt_ch ? d1 : d0;
        s_d          = gnt_ch;
        last_grant_d = gnt_ch;
      end else begin
        state_d = StEmpty;
      end
    end
  end

  // State registers; last_grant resets to 1 so channel 0 wins first contest.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StEmpty;
      y_q          <= '0;
      s_q          <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      s_q          <= s_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Directed bench for mux2_stream_arbiter (WIDTH = 8).
module tb_mux2_stream_arbiter;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d0, d1;
  logic             v0, v1;
  logic             r0, r1;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             s;

  int n_cmp;
  int n_err;

  mux2_stream_arbiter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .d0      (d0),
    .v0      (v0),
    .r0      (r0),
    .d1      (d1),
    .v1      (v1),
    .r1      (r1),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .s       (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs driven after this settle early.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e_y;
    logic       e_s;
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    v0      = 1'b1;
    v1      = 1'b1;
    d0      = 8'h00;
    d1      = 8'h00;
    y_ready = 1'b1;

    // Reset with both channels requesting
    tick();
    tick();
    check("rst_r0", r0, 0);
    check("rst_r1", r1, 0);
    check("rst_valid", y_valid, 0);
    check("rst_y", y, 0);
    check("rst_s", s, 0);

    rst = 1'b0;
    d0  = 8'h55;
    d1  = 8'h66;
    #1;
    check("first_r0", r0, 1);
    check("first_r1", r1, 0);
    tick();
    check("first_y", y, 8'h55);
    check("first_s", s, 0);
    check("first_valid", y_valid, 1);

    // Single channel 0, then single channel 1
    v0 = 1'b1; v1 = 1'b0; d0 = 8'hA5;
    tick();
    check("single0_y", y, 8'hA5);
    check("single0_s", s, 0);
    check("single0_valid", y_valid, 1);
    v0 = 1'b0; v1 = 1'b1; d1 = 8'h3C;
    tick();
    check("single1_y", y, 8'h3C);
    check("single1_s", s, 1);

    // Continuous contention; last grant was ch1 so ch0 goes first
    for (int n = 0; n < 6; n++) begin
      v0 = 1'b1; v1 = 1'b1;
      d0 = 8'h10 + 8'(n);
      d1 = 8'h20 + 8'(n);
`ifdef MUX2_ARB_FIXED_PRIO_EN
      e_s = 1'b0;
`else
      e_s = 1'(n % 2);
`endif
      e_y = e_s ? 8'h20 + 8'(n) : 8'h10 + 8'(n);
      #1;
      check("cont_r0", r0, {31'd0, ~e_s});
      check("cont_r1", r1, {31'd0, e_s});
      tick();
      check("cont_s", s, {31'd0, e_s});
      check("cont_y", y, {24'd0, e_y});
    end

    // Backpressure: hold 11 while ch1 waits
    v0 = 1'b1; v1 = 1'b0; d0 = 8'h11;
    tick();
    check("bp_load_y", y, 8'h11);
    y_ready = 1'b0; v0 = 1'b0; v1 = 1'b1; d1 = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_r0", r0, 0);
      check("bp_r1", r1, 0);
      tick();
      check("bp_hold_y", y, 8'h11);
      check("bp_hold_valid", y_valid, 1);
      check("bp_hold_s", s, 0);
    end
    y_ready = 1'b1;
    #1;
    check("bp_release_r1", r1, 1);
    tick();
    check("bp_release_y", y, 8'h77);
    check("bp_release_s", s, 1);

    // Mid-operation reset after a ch0 grant (last_grant=0)
    v0 = 1'b1; v1 = 1'b0; d0 = 8'h42;
    tick();
    check("pre_rst_y", y, 8'h42);
    y_ready = 1'b0; v0 = 1'b1; v1 = 1'b1; rst = 1'b1;
    #1;
    check("midrst_r0", r0, 0);
    check("midrst_r1", r1, 0);
    tick();
    check("midrst_valid", y_valid, 0);
    check("midrst_y", y, 0);
    check("midrst_s", s, 0);
    rst = 1'b0; y_ready = 1'b1; d0 = 8'h99; d1 = 8'h88;
    #1;
    check("post_rst_r0", r0, 1);
    check("post_rst_r1", r1, 0);
    tick();
    check("post_rst_y", y, 8'h99);
    check("post_rst_s", s, 0);

    // No requests: slot drains, y and s hold
    v0 = 1'b0; v1 = 1'b0;
    tick();
    check("drain_valid", y_valid, 0);
    check("drain_y", y, 8'h99);
    check("drain_s", s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
